// File: rtl/arvi_bus_pkg.sv
// Shared encodings for the I-cache / D-memory bus arbiter.
// Holds FSM states, grant codes and the fixed refill access size.
// No logic; imported by rr_pick2 and bus_arbiter.
package arvi_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef logic [1:0] grant_t;

  localparam grant_t GRANT_NONE = 2'b00;
  localparam grant_t GRANT_IC   = 2'b01;
  localparam grant_t GRANT_DM   = 2'b10;

  // I-cache refills are always whole words.
  localparam logic [2:0] F3_WORD = 3'b010;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of requester and memory-port signals around bus_arbiter.
// slave: the arbiter's view; master: the environment (caches + memory).
// Signal names keep the arbiter-relative i_/o_ prefixes on both sides.
interface bus_arbiter_if #(
  parameter int XLEN = 32
);

  logic            i_ic_req;
  logic [XLEN-1:0] i_ic_addr;
  logic [XLEN-1:0] o_ic_data;
  logic            o_ic_ready;

  logic            i_dm_rd;
  logic            i_dm_wr;
  logic [XLEN-1:0] i_dm_addr;
  logic [XLEN-1:0] i_dm_wd;
  logic [2:0]      i_dm_f3;
  logic [XLEN-1:0] o_dm_rdata;
  logic            o_dm_ready;

  logic            o_mem_req;
  logic            o_mem_wen;
  logic [XLEN-1:0] o_mem_addr;
  logic [XLEN-1:0] o_mem_wd;
  logic [2:0]      o_mem_f3;
  logic [XLEN-1:0] i_mem_rdata;
  logic            i_mem_ready;

  modport slave (
    input  i_ic_req, i_ic_addr,
    output o_ic_data, o_ic_ready,
    input  i_dm_rd, i_dm_wr, i_dm_addr, i_dm_wd, i_dm_f3,
    output o_dm_rdata, o_dm_ready,
    output o_mem_req, o_mem_wen, o_mem_addr, o_mem_wd, o_mem_f3,
    input  i_mem_rdata, i_mem_ready
  );

  modport master (
    output i_ic_req, i_ic_addr,
    input  o_ic_data, o_ic_ready,
    output i_dm_rd, i_dm_wr, i_dm_addr, i_dm_wd, i_dm_f3,
    input  o_dm_rdata, o_dm_ready,
    input  o_mem_req, o_mem_wen, o_mem_addr, o_mem_wd, o_mem_f3,
    output i_mem_rdata, i_mem_ready
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin tie-break: one-hot grant {DM, IC} from two requests.
// Latency: combinational, zero cycles.
// No backpressure; the caller decides when the grant is consumed.
module rr_pick2
  import arvi_bus_pkg::*;
(
  input  logic   req_ic_i,
  input  logic   req_dm_i,
  input  logic   last_dm_i,  // 1: DM won the previous arbitration
  output grant_t gnt_o
);

  // On a tie the requester that did not win last time gets the bus.
  always_comb begin
    gnt_o = GRANT_NONE;
    if (req_ic_i && req_dm_i) begin
      gnt_o = last_dm_i ? GRANT_IC : GRANT_DM;
    end else if (req_ic_i) begin
      gnt_o = GRANT_IC;
    end else if (req_dm_i) begin
      gnt_o = GRANT_DM;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates I-cache refills and data accesses onto one memory port (IDLE/BUSY/RESP).
// Latency: grant +1 cycle after request, ready pulse +1 cycle after i_mem_ready.
// Requesters hold until ready; BUSY stalls on memory (bounded if BUS_ARBITER_TIMEOUT_EN).
module bus_arbiter
  import arvi_bus_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic           i_clk,
  input  logic           i_rst,
  bus_arbiter_if.slave   bus,
  output grant_t         o_grant,
  output logic           o_timeout
);

  state_e          state_q, state_d;
  grant_t          owner_q, owner_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [2:0]      f3_q, f3_d;
  logic            wen_q, wen_d;
  logic            last_dm_q, last_dm_d;
  logic [XLEN-1:0] ic_data_q, ic_data_d;
  logic [XLEN-1:0] dm_data_q, dm_data_d;
  grant_t          pick;

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int            CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`else
  // Limit only matters when the stall timeout is compiled in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

  rr_pick2 u_pick (
    .req_ic_i  (bus.i_ic_req),
    .req_dm_i  (bus.i_dm_rd | bus.i_dm_wr),
    .last_dm_i (last_dm_q),
    .gnt_o     (pick)
  );

  // State and captured-transaction registers; reset aborts any transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= GRANT_NONE;
      addr_q    <= '0;
      wd_q      <= '0;
      f3_q      <= '0;
      wen_q     <= 1'b0;
      last_dm_q <= 1'b1;
      ic_data_q <= '0;
      dm_data_q <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      f3_q      <= f3_d;
      wen_q     <= wen_d;
      last_dm_q <= last_dm_d;
      ic_data_q <= ic_data_d;
      dm_data_q <= dm_data_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  // Next state, transaction capture/completion, and all outputs.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    f3_d      = f3_q;
    wen_d     = wen_q;
    last_dm_d = last_dm_q;
    ic_data_d = ic_data_q;
    dm_data_d = dm_data_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (pick != GRANT_NONE) begin
          state_d   = ST_BUSY;
          last_dm_d = (pick == GRANT_DM);
`ifdef BUS_ARBITER_TIMEOUT_EN
          cnt_d     = '0;
`endif
          if (pick == GRANT_IC) begin
            owner_d = GRANT_IC;
            addr_d  = bus.i_ic_addr;
            wd_d    = '0;
            f3_d    = F3_WORD;
            wen_d   = 1'b0;
          end else begin
            // rd and wr together is a write.
            owner_d = GRANT_DM;
            addr_d  = bus.i_dm_addr;
            wd_d    = bus.i_dm_wd;
            f3_d    = bus.i_dm_f3;
            wen_d   = bus.i_dm_wr;
          end
        end
      end
      ST_BUSY: begin
        if (bus.i_mem_ready) begin
          state_d = ST_RESP;
          if (owner_q == GRANT_IC) begin
            ic_data_d = bus.i_mem_rdata;
          end else if (!wen_q) begin
            dm_data_d = bus.i_mem_rdata;
          end
        end
`ifdef BUS_ARBITER_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          // Abandon the access: owner sees a completion carrying zero data.
          state_d   = ST_RESP;
          timeout_d = 1'b1;
          if (owner_q == GRANT_IC) begin
            ic_data_d = '0;
          end else if (!wen_q) begin
            dm_data_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    bus.o_mem_req  = (state_q == ST_BUSY);
    bus.o_mem_wen  = (state_q == ST_BUSY) && wen_q;
    bus.o_mem_addr = addr_q;
    bus.o_mem_wd   = wd_q;
    bus.o_mem_f3   = f3_q;
    bus.o_ic_data  = ic_data_q;
    bus.o_dm_rdata = dm_data_q;
    bus.o_ic_ready = (state_q == ST_RESP) && (owner_q == GRANT_IC);
    bus.o_dm_ready = (state_q == ST_RESP) && (owner_q == GRANT_DM);
    o_grant        = (state_q == ST_IDLE) ? GRANT_NONE : owner_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
    o_timeout      = timeout_q;
`else
    o_timeout      = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (timeout scenario when BUS_ARBITER_TIMEOUT_EN is defined).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each task checks its own scenario inline.
module tb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       timeout;
  int         errors = 0;
  int         checks = 0;

  bus_arbiter_if #(.XLEN(32)) bus ();

  bus_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .o_grant   (grant),
    .o_timeout (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a memory request, then answers it; returns in the RESP cycle.
  task automatic serve(input logic [31:0] rdata);
    for (int i = 0; i < 20; i++) begin
      if (bus.o_mem_req === 1'b1) break;
      tick();
    end
    checks++;
    if (bus.o_mem_req !== 1'b1) begin
      errors++; $display("FAIL serve_wait: o_mem_req=%b want 1", bus.o_mem_req);
    end
    bus.i_mem_ready = 1'b1;
    bus.i_mem_rdata = rdata;
    tick();
    bus.i_mem_ready = 1'b0;
    bus.i_mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.o_mem_req); end
    checks++; if (bus.o_mem_wen !== 1'b0) begin errors++; $display("FAIL rst_mem_wen: got %b want 0", bus.o_mem_wen); end
    checks++; if (bus.o_ic_ready !== 1'b0 || bus.o_dm_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got ic=%b dm=%b want 0 0", bus.o_ic_ready, bus.o_dm_ready); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant: got %b want 00", grant); end
    checks++; if (bus.o_ic_data !== 32'h0 || bus.o_dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_data: got ic=%h dm=%h want 0 0", bus.o_ic_data, bus.o_dm_rdata); end
    checks++; if (bus.o_mem_addr !== 32'h0 || bus.o_mem_wd !== 32'h0 || bus.o_mem_f3 !== 3'b0) begin errors++; $display("FAIL rst_captured: got addr=%h wd=%h f3=%b want 0", bus.o_mem_addr, bus.o_mem_wd, bus.o_mem_f3); end
    rst = 1'b0;
  endtask

  task automatic test_ic_read();
    // cycle 0: request seen in IDLE
    bus.i_ic_req  = 1'b1;
    bus.i_ic_addr = 32'h100;
    checks++; if (bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL ic_c0_mem_req: got %b want 0", bus.o_mem_req); end
    tick(); // cycle 1
    checks++; if (bus.o_mem_req !== 1'b1) begin errors++; $display("FAIL ic_c1_mem_req: got %b want 1", bus.o_mem_req); end
    checks++; if (bus.o_mem_addr !== 32'h100) begin errors++; $display("FAIL ic_c1_addr: got %h want 00000100", bus.o_mem_addr); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL ic_c1_grant: got %b want 01", grant); end
    checks++; if (bus.o_mem_wen !== 1'b0) begin errors++; $display("FAIL ic_c1_wen: got %b want 0", bus.o_mem_wen); end
    tick(); // cycle 2
    checks++; if (bus.o_mem_req !== 1'b1 || bus.o_ic_ready !== 1'b0) begin errors++; $display("FAIL ic_c2: got req=%b rdy=%b want 1 0", bus.o_mem_req, bus.o_ic_ready); end
    tick(); // cycle 3: memory answers
    bus.i_mem_ready = 1'b1;
    bus.i_mem_rdata = 32'h0000_0013;
    checks++; if (bus.o_ic_ready !== 1'b0) begin errors++; $display("FAIL ic_c3_ready: got %b want 0", bus.o_ic_ready); end
    tick(); // cycle 4: completion pulse
    bus.i_mem_ready = 1'b0;
    bus.i_mem_rdata = 32'h0;
    checks++; if (bus.o_ic_ready !== 1'b1) begin errors++; $display("FAIL ic_c4_ready: got %b want 1", bus.o_ic_ready); end
    checks++; if (bus.o_ic_data !== 32'h0000_0013) begin errors++; $display("FAIL ic_c4_data: got %h want 00000013", bus.o_ic_data); end
    checks++; if (bus.o_mem_req !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL ic_c4_resp: got req=%b grant=%b want 0 01", bus.o_mem_req, grant); end
    bus.i_ic_req = 1'b0;
    tick(); // cycle 5: back in IDLE
    checks++; if (bus.o_ic_ready !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL ic_c5_idle: got rdy=%b grant=%b want 0 00", bus.o_ic_ready, grant); end
    checks++; if (bus.o_ic_data !== 32'h0000_0013) begin errors++; $display("FAIL ic_c5_hold: got %h want 00000013", bus.o_ic_data); end
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_ic_req  = 1'b1;
    bus.i_ic_addr = 32'h80;
    bus.i_dm_rd   = 1'b1;
    bus.i_dm_addr = 32'h40;
    tick();
    checks++; if (grant !== 2'b01 || bus.o_mem_addr !== 32'h80) begin errors++; $display("FAIL rr_first: got grant=%b addr=%h want 01 00000080", grant, bus.o_mem_addr); end
    serve(32'h11);
    checks++; if (bus.o_ic_ready !== 1'b1 || bus.o_dm_ready !== 1'b0 || bus.o_ic_data !== 32'h11) begin errors++; $display("FAIL rr_first_resp: got ic=%b dm=%b data=%h want 1 0 00000011", bus.o_ic_ready, bus.o_dm_ready, bus.o_ic_data); end
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_gap: got grant=%b want 00", grant); end
    tick();
    checks++; if (grant !== 2'b10 || bus.o_mem_addr !== 32'h40 || bus.o_mem_wen !== 1'b0) begin errors++; $display("FAIL rr_second: got grant=%b addr=%h wen=%b want 10 00000040 0", grant, bus.o_mem_addr, bus.o_mem_wen); end
    serve(32'h22);
    checks++; if (bus.o_dm_ready !== 1'b1 || bus.o_ic_ready !== 1'b0 || bus.o_dm_rdata !== 32'h22) begin errors++; $display("FAIL rr_second_resp: got dm=%b ic=%b data=%h want 1 0 00000022", bus.o_dm_ready, bus.o_ic_ready, bus.o_dm_rdata); end
    tick();
    tick();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rr_third: got grant=%b want 01", grant); end
    serve(32'h33);
    tick();
    tick();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rr_fourth: got grant=%b want 10", grant); end
    serve(32'h44);
    checks++; if (bus.o_dm_rdata !== 32'h44 || bus.o_ic_data !== 32'h33) begin errors++; $display("FAIL rr_data: got dm=%h ic=%h want 00000044 00000033", bus.o_dm_rdata, bus.o_ic_data); end
    bus.i_ic_req = 1'b0;
    bus.i_dm_rd  = 1'b0;
    tick();
  endtask

  task automatic test_stray_ready();
    bus.i_mem_ready = 1'b1;
    bus.i_mem_rdata = 32'hFFFF_FFFF;
    tick();
    checks++; if (bus.o_ic_ready !== 1'b0 || bus.o_dm_ready !== 1'b0 || bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL stray_pulse: got ic=%b dm=%b req=%b want 0 0 0", bus.o_ic_ready, bus.o_dm_ready, bus.o_mem_req); end
    tick();
    checks++; if (bus.o_ic_data !== 32'h33 || bus.o_dm_rdata !== 32'h44) begin errors++; $display("FAIL stray_data: got ic=%h dm=%h want 00000033 00000044", bus.o_ic_data, bus.o_dm_rdata); end
    bus.i_mem_ready = 1'b0;
    bus.i_mem_rdata = 32'h0;
  endtask

  task automatic test_dm_write();
    bus.i_dm_wr   = 1'b1;
    bus.i_dm_rd   = 1'b1;
    bus.i_dm_addr = 32'h2000;
    bus.i_dm_wd   = 32'hDEAD_BEEF;
    bus.i_dm_f3   = 3'b010;
    tick();
    checks++; if (bus.o_mem_wen !== 1'b1 || bus.o_mem_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_busy: got wen=%b wd=%h want 1 deadbeef", bus.o_mem_wen, bus.o_mem_wd); end
    checks++; if (bus.o_mem_addr !== 32'h2000 || bus.o_mem_f3 !== 3'b010 || grant !== 2'b10) begin errors++; $display("FAIL wr_fields: got addr=%h f3=%b grant=%b want 00002000 010 10", bus.o_mem_addr, bus.o_mem_f3, grant); end
    bus.i_dm_addr = 32'h3000;
    bus.i_dm_wd   = 32'h0;
    bus.i_dm_f3   = 3'b000;
    bus.i_dm_wr   = 1'b0;
    tick();
    checks++; if (bus.o_mem_addr !== 32'h2000 || bus.o_mem_wd !== 32'hDEAD_BEEF || bus.o_mem_f3 !== 3'b010 || bus.o_mem_wen !== 1'b1) begin errors++; $display("FAIL wr_stable: got addr=%h wd=%h f3=%b wen=%b want 00002000 deadbeef 010 1", bus.o_mem_addr, bus.o_mem_wd, bus.o_mem_f3, bus.o_mem_wen); end
    bus.i_mem_ready = 1'b1;
    bus.i_mem_rdata = 32'hBAD0_BAD0;
    tick();
    bus.i_mem_ready = 1'b0;
    checks++; if (bus.o_dm_ready !== 1'b1 || bus.o_mem_wen !== 1'b0) begin errors++; $display("FAIL wr_resp: got rdy=%b wen=%b want 1 0", bus.o_dm_ready, bus.o_mem_wen); end
    checks++; if (bus.o_dm_rdata !== 32'h44) begin errors++; $display("FAIL wr_rdata_kept: got %h want 00000044", bus.o_dm_rdata); end
    bus.i_dm_rd = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_busy();
    bus.i_ic_req  = 1'b1;
    bus.i_ic_addr = 32'h500;
    tick();
    checks++; if (bus.o_mem_req !== 1'b1 || bus.o_mem_addr !== 32'h500) begin errors++; $display("FAIL rb_busy: got req=%b addr=%h want 1 00000500", bus.o_mem_req, bus.o_mem_addr); end
    rst = 1'b1;
    bus.i_mem_ready = 1'b1;
    tick();
    bus.i_mem_ready = 1'b0;
    checks++; if (bus.o_mem_req !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL rb_abort: got req=%b grant=%b want 0 00", bus.o_mem_req, grant); end
    checks++; if (bus.o_ic_ready !== 1'b0 || bus.o_mem_addr !== 32'h0 || bus.o_ic_data !== 32'h0) begin errors++; $display("FAIL rb_clear: got rdy=%b addr=%h data=%h want 0 0 0", bus.o_ic_ready, bus.o_mem_addr, bus.o_ic_data); end
    rst = 1'b0;
    bus.i_ic_req = 1'b0;
    tick();
    checks++; if (bus.o_ic_ready !== 1'b0 || bus.o_dm_ready !== 1'b0 || bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL rb_after: got ic=%b dm=%b req=%b want 0 0 0", bus.o_ic_ready, bus.o_dm_ready, bus.o_mem_req); end
  endtask

`ifdef BUS_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    bus.i_ic_req  = 1'b1;
    bus.i_ic_addr = 32'h600;
    tick();
    serve(32'h77);
    checks++; if (bus.o_ic_data !== 32'h77 || timeout !== 1'b0) begin errors++; $display("FAIL to_pre: got data=%h to=%b want 00000077 0", bus.o_ic_data, timeout); end
    tick(); // IDLE, request still held
    tick(); // first stalled BUSY cycle
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.o_mem_req !== 1'b1 || timeout !== 1'b0) begin errors++; $display("FAIL to_stall%0d: got req=%b to=%b want 1 0", i, bus.o_mem_req, timeout); end
      tick();
    end
    checks++; if (timeout !== 1'b1 || bus.o_ic_ready !== 1'b1) begin errors++; $display("FAIL to_pulse: got to=%b rdy=%b want 1 1", timeout, bus.o_ic_ready); end
    checks++; if (bus.o_ic_data !== 32'h0 || bus.o_mem_req !== 1'b0) begin errors++; $display("FAIL to_data: got data=%h req=%b want 0 0", bus.o_ic_data, bus.o_mem_req); end
    bus.i_ic_req = 1'b0;
    tick();
    checks++; if (timeout !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL to_idle: got to=%b grant=%b want 0 00", timeout, grant); end
  endtask
`else
  task automatic test_no_timeout();
    bus.i_ic_req  = 1'b1;
    bus.i_ic_addr = 32'h600;
    tick();
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.o_mem_req !== 1'b1 || timeout !== 1'b0 || bus.o_ic_ready !== 1'b0) begin errors++; $display("FAIL nt_stall: got req=%b to=%b rdy=%b want 1 0 0", bus.o_mem_req, timeout, bus.o_ic_ready); end
    serve(32'h55);
    checks++; if (bus.o_ic_ready !== 1'b1 || bus.o_ic_data !== 32'h55) begin errors++; $display("FAIL nt_resp: got rdy=%b data=%h want 1 00000055", bus.o_ic_ready, bus.o_ic_data); end
    bus.i_ic_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    bus.i_ic_req    = 1'b0;
    bus.i_ic_addr   = 32'h0;
    bus.i_dm_rd     = 1'b0;
    bus.i_dm_wr     = 1'b0;
    bus.i_dm_addr   = 32'h0;
    bus.i_dm_wd     = 32'h0;
    bus.i_dm_f3     = 3'b0;
    bus.i_mem_rdata = 32'h0;
    bus.i_mem_ready = 1'b0;

    test_reset();
    test_ic_read();
    test_round_robin();
    test_stray_ready();
    test_dm_write();
    test_reset_in_busy();
`ifdef BUS_ARBITER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, stall-cycle limit (used only with timeout compiled in).
REQ-003 SHALL have port i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_ic_req  input  1  I-cache refill request; held until o_ic_ready.
REQ-006 SHALL have port i_ic_addr  input  XLEN  refill address.
REQ-007 SHALL have port o_ic_data  output  XLEN  refill word.
REQ-008 SHALL have port o_ic_ready  output  1  one-cycle refill completion pulse.
REQ-009 SHALL have ports i_dm_rd / i_dm_wr  input  1 each  data read / write request; held until o_dm_ready.
REQ-010 SHALL have ports i_dm_addr  input  XLEN, i_dm_wd  input  XLEN, i_dm_f3  input  3  data access address, store data, size code.
REQ-011 SHALL have ports o_dm_rdata  output  XLEN, o_dm_ready  output  1  load data, one-cycle completion pulse.
REQ-012 SHALL have ports o_mem_req  output  1, o_mem_wen  output  1, o_mem_addr  output  XLEN, o_mem_wd  output  XLEN, o_mem_f3  output  3  shared memory port.
REQ-013 SHALL have ports i_mem_rdata  input  XLEN, i_mem_ready  input  1  memory response.
REQ-014 SHALL have ports o_grant  output  2  (01 IC, 10 DM, 00 none), o_timeout  output  1  timeout pulse.

Function
REQ-015 SHALL implement states IDLE, BUSY, RESP.
REQ-016 IDLE: any request -> capture owner, addr, wd, f3, wen into registers; next state BUSY.
REQ-017 Single requester in IDLE SHALL be granted; IC and DM both requesting SHALL grant the one not granted last (round-robin).
REQ-018 BUSY: o_mem_req=1, outputs driven from captured registers only, stable until exit; requester input changes ignored.
REQ-019 BUSY with i_mem_ready=1 -> register i_mem_rdata to owner's data output; next state RESP.
REQ-020 RESP: owner's ready=1 for exactly this cycle, o_mem_req=0, new requests ignored; next state IDLE.
REQ-021 Latency: request seen in IDLE cycle 0 -> o_mem_req cycle 1; i_mem_ready in cycle k -> ready pulse cycle k+1; minimum 3 cycles request-to-next-grant.
REQ-022 i_dm_rd and i_dm_wr both high SHALL be treated as a write; o_mem_wen=1 only for DM writes.
REQ-023 o_ic_data / o_dm_rdata SHALL hold last value until next completion for that owner; writes leave o_dm_rdata unchanged.
REQ-024 i_mem_ready outside BUSY SHALL be ignored.
REQ-025 o_grant SHALL equal owner in BUSY and RESP, 00 in IDLE.

Reset
REQ-026 i_rst=1 SHALL force IDLE next cycle, aborting any transaction; o_mem_req, o_mem_wen, o_ic_ready, o_dm_ready, o_timeout=0; o_grant=00; data outputs and captured registers=0; round-robin last-grant=DM (IC wins first tie).

Configuration
REQ-027 Macro BUS_ARBITER_TIMEOUT_EN defined: BUSY counter counts cycles without i_mem_ready; reaching TIMEOUT_CYCLES -> RESP, owner ready pulsed, data output 0, o_timeout=1 that cycle; counter cleared on BUSY entry.
REQ-028 Macro undefined: no counter, BUSY waits indefinitely, o_timeout tied 0.

Structure
REQ-029 Package arvi_bus_pkg SHALL hold state encoding and grant codes (GRANT_NONE, GRANT_IC, GRANT_DM).
REQ-030 Tie-break logic SHALL be sub-module rr_pick2 (two requests, last-grant in, one-hot grant out, combinational).

Verification
REQ-031 IC only, addr 0x100, memory ready 2 cycles after o_mem_req, rdata 0x00000013 -> o_mem_addr=0x100, o_ic_ready pulse cycle 4, o_ic_data=0x00000013.
REQ-032 IC and DM read same cycle after reset -> IC granted first; next tie -> DM; alternates thereafter.
REQ-033 DM write addr 0x2000, wd 0xDEADBEEF, f3=010, i_dm_rd also high -> o_mem_wen=1, o_mem_wd=0xDEADBEEF; o_dm_rdata unchanged.
REQ-034 i_dm_addr changed to 0x3000 during BUSY -> o_mem_addr stays 0x2000 until RESP.
REQ-035 i_rst=1 in BUSY -> next cycle o_mem_req=0, o_grant=00, no ready pulse.
REQ-036 With BUS_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, memory never ready -> o_timeout and owner ready pulse in the same cycle, data 0, then IDLE.
